// File: rtl/song_sequencer_if.sv
// Song sequencer bus: player controls, song ROM read port and voice outputs.
// master = controller/ROM side, slave = sequencer.
interface song_sequencer_if #(
    parameter int NUM_VOICES = 2,
    parameter int SONG_W     = 2,
    parameter int ENTRY_W    = 5,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int META_W     = 3
);
    localparam int WORD_W = 1 + NOTE_W + DUR_W + META_W;

    logic                         play;
    logic                         beat;
    logic [SONG_W-1:0]            song_sel;
    logic [SONG_W+ENTRY_W-1:0]    rom_addr;
    logic [WORD_W-1:0]            rom_data;
    logic [NUM_VOICES*NOTE_W-1:0] notes;
    logic [NUM_VOICES-1:0]        voice_load;
    logic [META_W-1:0]            meta_out;
    logic                         busy;
    logic                         song_done;
    logic                         chord_ovf;

    modport master (
        output play, beat, song_sel, rom_data,
        input  rom_addr, notes, voice_load, meta_out, busy, song_done, chord_ovf
    );

    modport slave (
        input  play, beat, song_sel, rom_data,
        output rom_addr, notes, voice_load, meta_out, busy, song_done, chord_ovf
    );
endinterface

// File: rtl/song_sequencer.sv
// Multi-voice song player: walks a registered song ROM, groups chords, holds them for beat counts.
// Latency: 3 edges from play in IDLE to first voice_load; 2 cycles per ROM entry.
// Backpressure: play=0 freezes only the HOLD countdown; SONG_LOOP_EN replays the latched song forever.
module song_sequencer #(
    parameter int NUM_VOICES = 2,
    parameter int SONG_W     = 2,
    parameter int ENTRY_W    = 5,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int META_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    song_sequencer_if.slave  bus
);
    localparam int VI_W = $clog2(NUM_VOICES + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, HOLD} state_t;

    typedef struct packed {
        logic              advance;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
        logic [META_W-1:0] meta;
    } entry_t;

    state_t                       state;
    logic [SONG_W-1:0]            song_q;
    logic [ENTRY_W-1:0]           entry_idx;
    logic [VI_W-1:0]              voice_idx;
    logic [DUR_W-1:0]             hold_cnt;
    logic [NUM_VOICES*NOTE_W-1:0] notes_q;
    logic [NUM_VOICES-1:0]        voice_load_q;
    logic [META_W-1:0]            meta_q;
    logic [SONG_W+ENTRY_W-1:0]    rom_addr_q;
    logic                         song_done_q;
    logic                         chord_ovf_q;

    entry_t             ent;
    logic [ENTRY_W-1:0] entry_nxt;
    logic               last_entry;
    logic               tick;

    assign ent        = entry_t'(bus.rom_data);
    assign entry_nxt  = entry_idx + ENTRY_W'(1);
    assign last_entry = &entry_idx;
    assign tick       = bus.beat & bus.play;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            song_q       <= '0;
            entry_idx    <= '0;
            voice_idx    <= '0;
            hold_cnt     <= '0;
            notes_q      <= '0;
            voice_load_q <= '0;
            meta_q       <= '0;
            rom_addr_q   <= '0;
            song_done_q  <= 1'b0;
            chord_ovf_q  <= 1'b0;
        end else begin
            voice_load_q <= '0;
            song_done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.play) begin
                        song_q      <= bus.song_sel;
                        entry_idx   <= '0;
                        voice_idx   <= '0;
                        notes_q     <= '0;
                        chord_ovf_q <= 1'b0;
                        rom_addr_q  <= {bus.song_sel, {ENTRY_W{1'b0}}};
                        state       <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    // Notes beyond the voice count are dropped but still advance the chord.
                    if (voice_idx < VI_W'(NUM_VOICES)) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (voice_idx == VI_W'(v)) begin
                                notes_q[v*NOTE_W +: NOTE_W] <= ent.note;
                                voice_load_q[v]             <= 1'b1;
                            end
                        end
                        voice_idx <= voice_idx + VI_W'(1);
                    end else begin
                        chord_ovf_q <= 1'b1;
                    end
                    meta_q <= ent.meta;
                    if (!ent.advance && !last_entry) begin
                        entry_idx  <= entry_nxt;
                        rom_addr_q <= {song_q, entry_nxt};
                        state      <= FETCH;
                    end else begin
                        hold_cnt <= (ent.dur == '0) ? DUR_W'(1) : ent.dur;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt == DUR_W'(1)) begin
                            notes_q   <= '0;
                            voice_idx <= '0;
                            if (!last_entry) begin
                                entry_idx  <= entry_nxt;
                                rom_addr_q <= {song_q, entry_nxt};
                                state      <= FETCH;
                            end else begin
                                song_done_q <= 1'b1;
`ifdef SONG_LOOP_EN
                                entry_idx  <= '0;
                                rom_addr_q <= {song_q, {ENTRY_W{1'b0}}};
                                state      <= FETCH;
`else
                                state      <= IDLE;
`endif
                            end
                        end else begin
                            hold_cnt <= hold_cnt - DUR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.notes      = notes_q;
    assign bus.voice_load = voice_load_q;
    assign bus.meta_out   = meta_q;
    assign bus.busy       = (state != IDLE);
    assign bus.song_done  = song_done_q;
    assign bus.chord_ovf  = chord_ovf_q;
endmodule
